// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter sharing the single data memory port
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic [DATA_WIDTH-1:0] r0_addr,
    input  logic [2:0]            r0_ctrl,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_gnt,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    output logic                  r0_err,
    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic [DATA_WIDTH-1:0] r1_addr,
    input  logic [2:0]            r1_ctrl,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_gnt,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  r1_err,
    output logic [DATA_WIDTH-1:0] mem_a,
    output logic                  mem_we,
    output logic [2:0]            mem_ctrl,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  rr_q, rr_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  any_req, both_req, win;
    logic                  gnt0, gnt1;
    logic                  sel_we, sel_err;
    logic [DATA_WIDTH-1:0] sel_addr, sel_wdata;
    logic [2:0]            sel_ctrl;

    // Pick the winning port and decode whether its access is misaligned or illegal
    always_comb begin
        both_req = r0_req & r1_req;
        any_req  = r0_req | r1_req;
        if (both_req) begin
            win = FIXED_PRIO ? 1'b0 : rr_q;
        end else begin
            win = r1_req;
        end
        sel_we    = win ? r1_we    : r0_we;
        sel_addr  = win ? r1_addr  : r0_addr;
        sel_ctrl  = win ? r1_ctrl  : r0_ctrl;
        sel_wdata = win ? r1_wdata : r0_wdata;
        case (sel_ctrl[1:0])
            2'b00:   sel_err = 1'b0;
            2'b01:   sel_err = sel_addr[0];
            2'b10:   sel_err = |sel_addr[1:0];
            default: sel_err = 1'b1;
        endcase
    end

    // Next state: grant and latch in IDLE/RESP, run the memory cycle in ACCESS
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        ctrl_d  = ctrl_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (any_req) begin
                    gnt0    = ~win;
                    gnt1    = win;
                    owner_d = win;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    ctrl_d  = sel_ctrl;
                    wdata_d = sel_wdata;
                    err_d   = sel_err;
                    state_d = ACCESS;
                    // the loser of a contested round is favoured next time
                    if (both_req && !FIXED_PRIO) begin
                        rr_d = ~win;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                rdata_d = (we_q | err_q) ? '0 : mem_rd;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, round-robin pointer and latched request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            ctrl_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            ctrl_q  <= ctrl_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Grants are combinational but held low while reset is asserted
    assign r0_gnt    = gnt0 & rst_n;
    assign r1_gnt    = gnt1 & rst_n;
    assign r0_rvalid = (state_q == RESP) & ~owner_q;
    assign r1_rvalid = (state_q == RESP) & owner_q;
    assign r0_rdata  = r0_rvalid ? rdata_q : '0;
    assign r1_rdata  = r1_rvalid ? rdata_q : '0;
    assign r0_err    = r0_rvalid & err_q;
    assign r1_err    = r1_rvalid & err_q;
    // Memory sees the latched request; only ACCESS of a legal store writes
    assign mem_a     = addr_q;
    assign mem_ctrl  = ctrl_q;
    assign mem_wd    = wdata_q;
    assign mem_we    = (state_q == ACCESS) & we_q & ~err_q;
endmodule
